// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters: port 0, the CPU
// execute stage, and port 1, the auxiliary/coprocessor sequencer.
//
// For each operation the block:
//   - grants one of the two ports,
//   - latches that port's opcode and operands onto the ALU inputs,
//   - holds alu_enable for LAT settle cycles,
//   - registers the ALU result and the {sign, zero, carry} flags.
//
// Each port has its own carry flag. The granted port's carry feeds the
// ALU cpu_carry input.
//
// Optional feature (compile-time macro ALU_ARB_RR_EN):
//   defined   : simultaneous requests are resolved round-robin.
//   undefined : fixed priority, port 0 always wins a tie.
//
// Parameter:
//   LAT            ALU settle cycles per operation (1..4)
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   req0/req1      requests from port 0 / port 1
//   op0/op1_code   opcodes from port 0 / port 1
//   a0,b0/a1,b1    operands from port 0 / port 1
//   ack0/ack1      one-cycle pulse: request accepted, operands latched
//   done0/done1    one-cycle pulse: result valid on res_*
//   res_l/res_h    registered result, held until the next capture
//   res_flags      registered {sign, zero, carry} of the last operation
//   carry0/carry1  per-port carry flags
//   alu_*          outputs drive the ALU inputs; alu_result_*, alu_carry,
//                  alu_zero and alu_sign are the ALU outputs
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] op0,
  input  logic [7:0] op1_code,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] res_l,
  output logic [7:0] res_h,
  output logic [2:0] res_flags,
  output logic       carry0,
  output logic       carry1,
  output logic       alu_enable,
  output logic [7:0] alu_operation,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  output logic       alu_cpu_carry,
  input  logic [7:0] alu_result_l,
  input  logic [7:0] alu_result_h,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_sign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter counts down to zero, so its load value is LAT-1.
  localparam logic [1:0] CNT_LOAD = 2'(LAT - 1);

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] cnt_reg;
  logic       gnt_reg;
  logic [1:0] ack_reg;
  logic [1:0] carry_reg;

  logic       any_req;
  logic       grant;
  logic       gnt_sel;
  logic       capture;
  logic       cur_carry;
  logic       carry_op;
  logic       new_carry;
  logic [1:0] carry_load;
  logic [1:0] done_vec;

  // Only these opcodes produce a carry that the requester owns:
  //   0x88-0x8B ADD, 0x02 INC, 0x04 SETC, 0x05 CLRC, 0x08 RLC, 0x09 RRC.
  // For every other opcode the ALU carry output is ignored.
  function automatic logic is_carry_op(input logic [7:0] op);
    return (op[7:2] == 6'b100010) || (op == 8'h02) || (op == 8'h04) ||
           (op == 8'h05) || (op == 8'h08) || (op == 8'h09);
  endfunction

  assign any_req = req0 | req1;
  assign grant   = (state_reg == ST_IDLE) && any_req;

`ifdef ALU_ARB_RR_EN
  // Holds the port granted last. On a tie, the other port wins.
  logic last_gnt_reg;

  always_comb begin
    if (req0 && req1) gnt_sel = ~last_gnt_reg;
    else              gnt_sel = ~req0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_gnt_reg <= 1'b1;
    else if (grant) last_gnt_reg <= gnt_sel;
  end
`else
  // Fixed priority: port 1 wins only when port 0 is not requesting.
  assign gnt_sel = ~req0;
`endif

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    alu_enable    = 1'b0;
    alu_cpu_carry = 1'b0;
    capture       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        alu_enable    = 1'b1;
        alu_cpu_carry = cur_carry;
        if (cnt_reg == 2'd0) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------ datapath
  assign cur_carry = carry_reg[gnt_reg];
  assign carry_op  = is_carry_op(alu_operation);
  assign new_carry = carry_op ? alu_carry : cur_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= 2'd0;
      gnt_reg       <= 1'b0;
      ack_reg       <= 2'b00;
      alu_operation <= 8'h00;
      alu_op1       <= 8'h00;
      alu_op2       <= 8'h00;
      res_l         <= 8'h00;
      res_h         <= 8'h00;
      res_flags     <= 3'b000;
    end else begin
      ack_reg <= 2'b00;
      if (grant) begin
        gnt_reg       <= gnt_sel;
        cnt_reg       <= CNT_LOAD;
        ack_reg       <= gnt_sel ? 2'b10 : 2'b01;
        alu_operation <= gnt_sel ? op1_code : op0;
        alu_op1       <= gnt_sel ? a1 : a0;
        alu_op2       <= gnt_sel ? b1 : b0;
      end else if ((state_reg == ST_EXEC) && (cnt_reg != 2'd0)) begin
        cnt_reg <= cnt_reg - 2'd1;
      end
      if (capture) begin
        res_l     <= alu_result_l;
        res_h     <= alu_result_h;
        res_flags <= {alu_sign, alu_zero, new_carry};
      end
    end
  end

  // Per-port carry load enables and done pulses.
  // Only the granted port's carry can change.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam logic PORT = (gi == 1);
    assign carry_load[gi] = capture && carry_op && (gnt_reg == PORT);
    assign done_vec[gi]   = (state_reg == ST_DONE) && (gnt_reg == PORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) carry_reg <= 2'b00;
    else     carry_reg <= (carry_load & {2{alu_carry}}) | (~carry_load & carry_reg);
  end

  assign ack0   = ack_reg[0];
  assign ack1   = ack_reg[1];
  assign done0  = done_vec[0];
  assign done1  = done_vec[1];
  assign carry0 = carry_reg[0];
  assign carry1 = carry_reg[1];

endmodule
